// File: rtl/mant_sub_pkg.sv
// Shared parameters and state encoding for the serial mantissa subtractor.
package mant_sub_pkg;

    localparam int WIDTH  = 24;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = $clog2(NSLICE);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SLICE-1:0] slice_t;
    typedef logic [IW-1:0]    idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG,
        DONE
    } state_e;

endpackage

// File: rtl/mant_subtractor_serial_if.sv
// Operand/result handshake bundle for the serial mantissa subtractor.
interface mant_subtractor_serial_if;
    import mant_sub_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t A;
    word_t B;
    logic  abs_mode;
    logic  out_valid;
    logic  out_ready;
    word_t Diff;
    logic  Borrow;
    logic  Zero;

    modport master (
        output in_valid, A, B, abs_mode, out_ready,
        input  in_ready, out_valid, Diff, Borrow, Zero
    );

    modport slave (
        input  in_valid, A, B, abs_mode, out_ready,
        output in_ready, out_valid, Diff, Borrow, Zero
    );

endinterface

// File: rtl/mant_subtractor_serial_cla.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla_slice_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/mant_subtractor_serial.sv
// Serial 24-bit mantissa subtractor: one CLA slice per clock,
// optional two's-complement pass to return |A-B|.
module mant_subtractor_serial
    import mant_sub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mant_subtractor_serial_if.slave bus
);

    state_e state_q, state_d;

    word_t opa, opb, res, res_n;
    logic  carry, abs_r, borrow_q, zero_q;
    idx_t  idx;

    slice_t a_sl, b_sl, s_sl;
    logic   cout, last;

    cla_slice_4bit u_cla (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (cout)
    );

    assign last = (idx == idx_t'(NSLICE - 1));
    assign a_sl = opa[idx*SLICE +: SLICE];
    assign b_sl = opb[idx*SLICE +: SLICE];

    // res with the slice computed this cycle already merged in
    always_comb begin
        res_n = res;
        res_n[idx*SLICE +: SLICE] = s_sl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = SUB;
            SUB:  if (last) state_d = (!cout && abs_r) ? NEG : DONE;
            NEG:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            abs_r    <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.A;
                        opb   <= ~bus.B;
                        carry <= 1'b1;
                        idx   <= '0;
                        abs_r <= bus.abs_mode;
                    end
                end
                SUB: begin
                    res   <= res_n;
                    carry <= cout;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        borrow_q <= ~cout;
                        zero_q   <= (res_n == '0);
                        // negative result: reload for the two's-complement pass
                        if (!cout && abs_r) begin
                            opa   <= ~res_n;
                            opb   <= '0;
                            carry <= 1'b1;
                        end
                    end
                end
                NEG: begin
                    res   <= res_n;
                    carry <= cout;
                    idx   <= last ? '0 : idx + 1'b1;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Diff      = res;
    assign bus.Borrow    = borrow_q;
    assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_mant_subtractor_serial.sv
// Directed plus randomized check of the serial mantissa subtractor
// against an arithmetic reference model.
module tb_mant_subtractor_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    mant_subtractor_serial_if bus ();

    mant_subtractor_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input logic ab, input int hold);
        logic [24:0] full;
        logic [23:0] ediff;
        logic        eborrow, ezero;
        int          elat, cnt;
        eborrow = (a < b);
        ezero   = (a == b);
        full    = {1'b0, a} - {1'b0, b};
        ediff   = full[23:0];
        if (ab && eborrow) begin
            full  = {1'b0, b} - {1'b0, a};
            ediff = full[23:0];
        end
        elat = (ab && eborrow) ? 12 : 6;

        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.abs_mode = ab;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 24'($urandom);
        bus.B        = 24'($urandom);
        cnt = 0;
        while (!bus.out_valid && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(elat));
        chk("diff", 32'(bus.Diff), 32'(ediff));
        chk("borrow", 32'(bus.Borrow), 32'(eborrow));
        chk("zero", 32'(bus.Zero), 32'(ezero));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_diff", 32'(bus.Diff), 32'(ediff));
            chk("hold_flags", 32'({bus.Borrow, bus.Zero}),
                32'({eborrow, ezero}));
        end

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_ready", 32'(bus.in_ready), 32'd1);
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_diff", 32'(bus.Diff), 32'(ediff));
    endtask

    initial begin
        logic [23:0] ra, rb;
        int cnt;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.abs_mode  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.Diff), 32'd0);
        chk("rst_flags", 32'({bus.Borrow, bus.Zero}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(24'h000005, 24'h000003, 1'b0, 0);
        run_op(24'h000003, 24'h000005, 1'b0, 0);
        run_op(24'h000003, 24'h000005, 1'b1, 0);
        run_op(24'h100000, 24'h000001, 1'b0, 0);
        run_op(24'h000000, 24'h000001, 1'b1, 0);
        run_op(24'h800000, 24'h800000, 1'b1, 0);
        run_op(24'h000000, 24'h800000, 1'b1, 0);
        run_op(24'hFFFFFF, 24'h000000, 1'b1, 5);

        // abort mid-computation at slice 3
        @(negedge clk);
        bus.A        = 24'h123456;
        bus.B        = 24'h654321;
        bus.abs_mode = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_diff", 32'(bus.Diff), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        chk("abort_no_result", 32'(cnt), 32'd0);
        run_op(24'h00FFFF, 24'h000001, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 24'($urandom);
            rb = (i % 4 == 0) ? ra ^ 24'(1 << (i % 24)) : 24'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mant_subtractor_serial.md
# mant_subtractor_serial

Multi-cycle 24-bit mantissa subtractor for the effective-subtraction path of the power-efficient floating-point adder. It computes A − B one 4-bit carry-lookahead slice per clock, trading latency for a single small adder. An optional second pass returns the magnitude |A − B|. Operands arrive and results leave on valid/ready handshakes, so the block sits between the alignment stage and the normalisation stage.

## Interface
- WIDTH, 24, operand/result width; must be a multiple of SLICE
- SLICE, 4, bits processed per cycle (width of the CLA slice)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/abs_mode valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- A  in  WIDTH  minuend
- B  in  WIDTH  subtrahend
- abs_mode  in  1  1: return |A−B|; 0: return A−B mod 2^WIDTH
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Diff  out  WIDTH  result
- Borrow  out  1  1 when A < B (unsigned)
- Zero  out  1  1 when A == B

## Operation
- Datapath: registers opa, opb (holds ~B), res, carry, slice index idx (0..NSLICE−1, NSLICE = WIDTH/SLICE), abs_r.
- IDLE: in_ready=1. On in_valid && in_ready: opa←A, opb←~B, carry←1, idx←0, abs_r←abs_mode; go to SUB.
- SUB: each cycle, CLA computes opa[idx slice] + opb[idx slice] + carry. Result goes to res[idx slice], carry←cout, idx←idx+1.
  - On the last slice (idx=NSLICE−1): Borrow←~cout, Zero←(final res==0, including the slice written this cycle).
  - If ~cout && abs_r: go to NEG with opa←~res (final value), opb←0, carry←1, idx←0.
  - Otherwise go to DONE.
- NEG: same slice adder, NSLICE cycles, res slices overwritten. After the last slice, go to DONE. Borrow and Zero are unchanged in NEG.
- DONE: out_valid=1; Diff=res. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. A and B are sampled only at the accept edge.
- Diff, Borrow and Zero hold stable from out_valid rise until handshake, and remain holding their last values in IDLE.
- Wrap-around: carry out of the last slice is consumed only as the Borrow flag. Diff is always mod 2^WIDTH.
- Special case: abs_mode with A−B = −2^(WIDTH−1) still yields 0x800000 (magnitude fits the unsigned width; no overflow possible).

## Timing
- Reset values (async, immediate): state=IDLE, in_ready=1, out_valid=0, Diff=0, Borrow=0, Zero=0, idx=0, carry=0.
- Reset mid-operation aborts the computation; no partial result is ever presented.
- Latency from the accept edge to out_valid high:
  - NSLICE (6) cycles when there is no NEG pass.
  - 2·NSLICE (12) cycles when abs_mode=1 and A<B.
- Minimum accept-to-accept interval is NSLICE+2 (8) cycles, reached with out_ready held high. DONE lasts at least 1 cycle, and IDLE lasts at least 1 cycle.
- Handshake: a transfer occurs on a rising edge where valid && ready are both high. out_valid does not depend combinationally on out_ready. in_ready is a function of state only.

## Structure
- Package mant_sub_pkg holds:
  - WIDTH, SLICE, NSLICE localparams.
  - State enum {IDLE, SUB, NEG, DONE}.
- One combinational sub-module, cla_slice_4bit (SLICE-bit carry-lookahead: inputs a, b, cin; outputs s, cout), instantiated once. The top module holds the FSM, operand and result registers, and slice muxing.

## Test plan
- A=0x000005, B=0x000003, abs_mode=0 -> Diff=0x000002, Borrow=0, Zero=0, out_valid exactly 6 cycles after the accept edge.
- A=0x000003, B=0x000005 -> abs_mode=0 gives Diff=0xFFFFFE, Borrow=1 at 6 cycles; abs_mode=1 gives Diff=0x000002, Borrow=1 at 12 cycles.
- Full borrow chain: A=0x100000, B=0x000001 -> Diff=0x0FFFFF, Borrow=0. Also A=0x000000, B=0x000001, abs_mode=1 -> Diff=0x000001, Borrow=1.
- A=B=0x800000 -> Diff=0x000000, Zero=1, Borrow=0, no NEG pass even with abs_mode=1 (6-cycle latency).
- Backpressure: out_ready held low 5 cycles in DONE -> Diff, Borrow and Zero stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready rises the next cycle and a new operand pair is accepted.
- rst asserted during SUB at idx=3 -> immediately in_ready=1, out_valid=0, Diff=0. After release, A=0x00FFFF, B=0x000001 yields Diff=0x00FFFE at 6 cycles.
